// File: rtl/board_io_pkg.sv
// Shared board-level I/O definitions: step FSM encoding and 50 MHz timing defaults.
package board_io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRE   = 2'd1,
        HOLD   = 2'd2,
        REPEAT = 2'd3
    } step_state_t;

    // 10 ms debounce, 0.5 s to first repeat, 10 steps/s thereafter
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stable-count debouncer; reusable for any push-button.
module debounce_filter
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

    logic        sync_q;
    logic        sw_s;
    logic [23:0] db_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b0;
            sw_s   <= 1'b0;
            db_cnt <= '0;
            level  <= 1'b0;
        end else begin
            sync_q <= raw;
            sw_s   <= sync_q;
            // any return to agreement restarts the stability window
            if (sw_s == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level  <= ~level;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 24'd1;
            end
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Debounced single-step pulse generator with optional auto-repeat and a wrapping step counter.
module step_pulse_gen
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sw_input,
    output logic        step_pulse,
    output logic        pressed,
    output logic [15:0] step_count
);

    localparam logic [31:0] RPT_DELAY_LD  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RPT_PERIOD_LD = 32'(REPEAT_PERIOD - 1);

    step_state_t state, state_nxt;
    logic [31:0] rpt_cnt, rpt_nxt;

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk   (clk),
        .reset (reset),
        .raw   (sw_input),
        .level (pressed)
    );

    // Every path back to IDLE requires pressed low, so pressed high in IDLE is always a fresh rise.
    always_comb begin
        state_nxt = state;
        rpt_nxt   = rpt_cnt;
        case (state)
            IDLE: if (pressed) state_nxt = FIRE;
            FIRE: begin
                if (pressed) begin
                    state_nxt = HOLD;
                    rpt_nxt   = RPT_DELAY_LD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (!pressed) begin
                    state_nxt = IDLE;
                end else if (REPEAT_EN) begin
                    if (rpt_cnt == 32'd0) state_nxt = REPEAT;
                    else                  rpt_nxt   = rpt_cnt - 32'd1;
                end
            end
            REPEAT: begin
                if (pressed) begin
                    state_nxt = HOLD;
                    rpt_nxt   = RPT_PERIOD_LD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rpt_cnt    <= '0;
            step_pulse <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= state_nxt;
            rpt_cnt    <= rpt_nxt;
            // registered so the pulse is aligned with the FIRE/REPEAT state and glitch-free
            step_pulse <= (state_nxt == FIRE) || (state_nxt == REPEAT);
            if (step_pulse) step_count <= step_count + 16'd1;
        end
    end

endmodule
